// File: rtl/spimem_cache_pkg.sv
// Shared types and geometry constants for the SPI-flash read cache.
package spimem_cache_pkg;

    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned BYTE_BITS   = 2;
    localparam int unsigned ADDR_BITS   = 24;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StResp
    } state_e;

endpackage

// File: rtl/spimem_cache_data.sv
// Cache data store: flop array with asynchronous read and synchronous write.
module spimem_cache_data
    import spimem_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    localparam int unsigned AW = $clog2(NUM_LINES * LINE_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [NUM_LINES*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/spimem_cache.sv
// Direct-mapped read cache (4-word lines) in front of a SPI flash controller.
// Define SPIMEM_CACHE_STATS_EN to add hit_cnt/miss_cnt statistics outputs.
module spimem_cache
    import spimem_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [23:0] addr,
    output logic [31:0] rdata,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_rdata
`ifdef SPIMEM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
    localparam int unsigned LOW_BITS = OFFSET_BITS + BYTE_BITS;
    localparam int unsigned TAG_BITS = ADDR_BITS - LOW_BITS - IDX_BITS;
    localparam int unsigned WA_BITS  = IDX_BITS + OFFSET_BITS;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   line_valid_q, line_valid_d;
    logic [TAG_BITS-1:0]    tag_arr_q [NUM_LINES];
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [OFFSET_BITS-1:0] off_q, off_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   ready_d, mem_valid_d, tag_we;
    logic [31:0]            rdata_d;
    logic [23:0]            mem_addr_d;

    logic [TAG_BITS-1:0]    req_tag;
    logic [IDX_BITS-1:0]    req_idx;
    logic [OFFSET_BITS-1:0] req_off;
    logic [OFFSET_BITS-1:0] fill_off;
    logic                   hit, accept, beat, last_beat;
    logic [WA_BITS-1:0]     raddr;
    logic [31:0]            rd_word;
    logic                   unused_addr;

    assign req_tag   = addr[ADDR_BITS-1 -: TAG_BITS];
    assign req_idx   = addr[LOW_BITS +: IDX_BITS];
    assign req_off   = addr[BYTE_BITS +: OFFSET_BITS];
    assign fill_off  = mem_addr[BYTE_BITS +: OFFSET_BITS];
    assign hit       = line_valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);
    assign accept    = (state_q == StIdle) && valid && !ready && !flush;
    assign beat      = mem_valid && mem_ready;
    assign last_beat = beat && (fill_off == '1);
    assign unused_addr = ^addr[BYTE_BITS-1:0];

    // Read port serves the live request in IDLE and the latched miss afterwards.
    assign raddr = (state_q == StIdle) ? {req_idx, req_off} : {idx_q, off_q};

    spimem_cache_data #(
        .NUM_LINES (NUM_LINES)
    ) u_data (
        .clk   (clk),
        .we    (beat),
        .waddr ({idx_q, fill_off}),
        .wdata (mem_rdata),
        .raddr (raddr),
        .rdata (rd_word)
    );

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        off_d        = off_q;
        flush_pend_d = flush_pend_q;
        ready_d      = 1'b0;
        rdata_d      = rdata;
        mem_valid_d  = mem_valid;
        mem_addr_d   = mem_addr;
        tag_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        rdata_d = rd_word;
                    end else begin
                        tag_d                 = req_tag;
                        idx_d                 = req_idx;
                        off_d                 = req_off;
                        line_valid_d[req_idx] = 1'b0;
                        mem_addr_d            = {req_tag, req_idx, LOW_BITS'(0)};
                        mem_valid_d           = 1'b1;
                        flush_pend_d          = 1'b0;
                        state_d               = StFill;
                    end
                end
            end
            StFill: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (beat) begin
                    // Only the word offset advances, so the fill never leaves its line.
                    mem_addr_d = {mem_addr[ADDR_BITS-1:LOW_BITS], fill_off + OFFSET_BITS'(1),
                                  BYTE_BITS'(0)};
                    if (last_beat) begin
                        mem_valid_d = 1'b0;
                        state_d     = StResp;
                        if (!flush_pend_q && !flush) begin
                            line_valid_d[idx_q] = 1'b1;
                            tag_we              = 1'b1;
                        end
                    end
                end
            end
            StResp: begin
                ready_d = 1'b1;
                rdata_d = rd_word;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            line_valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            line_valid_q <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            off_q        <= '0;
            flush_pend_q <= 1'b0;
            ready        <= 1'b0;
            rdata        <= '0;
            mem_valid    <= 1'b0;
            mem_addr     <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            off_q        <= off_d;
            flush_pend_q <= flush_pend_d;
            ready        <= ready_d;
            rdata        <= rdata_d;
            mem_valid    <= mem_valid_d;
            mem_addr     <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_arr_q[idx_q] <= tag_q;
        end
    end

`ifdef SPIMEM_CACHE_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spimem_cache.sv
// Directed self-checking bench for spimem_cache with a delay-programmable flash responder.
module tb_spimem_cache;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic [23:0] addr;
    logic [31:0] rdata;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
`ifdef SPIMEM_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int          n_cmp;
    int          n_err;
    int          fill_cnt;
    int          max_delay;
    logic [23:0] fill_log [$];

    spimem_cache #(
        .NUM_LINES (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .ready     (ready),
        .addr      (addr),
        .rdata     (rdata),
        .flush     (flush),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
`ifdef SPIMEM_CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'hA5, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 1000) begin
            tick();
            lat++;
            if (ready) break;
        end
    endtask

    // Issues a read, waits for ready, then checks the pulse ends and rdata holds.
    task automatic cpu_read(input string tag, input logic [23:0] a, input logic [31:0] exp_d,
                            input int exp_lat);
        int          lat;
        logic [31:0] d;
        valid = 1'b1;
        addr  = a;
        wait_ready(lat);
        d     = rdata;
        valid = 1'b0;
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_rdata"}, d, exp_d);
        if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
        tick();
        check({tag, "_ready_pulse"}, {31'd0, ready}, 32'd0);
        check({tag, "_rdata_hold"}, rdata, exp_d);
    endtask

    task automatic check_fills(input string tag, input logic [23:0] base);
        check({tag, "_fill_count"}, fill_log.size(), 4);
        for (int i = 0; i < 4 && i < fill_log.size(); i++) begin
            check({tag, "_fill_addr"}, {8'h0, fill_log[i]}, {8'h0, base + 24'(4 * i)});
        end
        fill_log.delete();
    endtask

    // Flash responder: pulses mem_ready after a random wait, checks mem_addr stability.
    initial begin : responder
        int          wait_cnt;
        logic        prev_wait;
        logic [23:0] prev_addr;
        wait_cnt  = 0;
        prev_wait = 1'b0;
        prev_addr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (prev_wait && mem_valid) begin
                check("mem_addr_stable", {8'h0, mem_addr}, {8'h0, prev_addr});
            end
            if (mem_valid && resetn) begin
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    fill_log.push_back(mem_addr);
                    fill_cnt++;
                    wait_cnt = int'($urandom_range(max_delay, 0));
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = int'($urandom_range(max_delay, 0));
            end
            prev_wait = mem_valid && !mem_ready;
            prev_addr = mem_addr;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        int start;
        n_cmp     = 0;
        n_err     = 0;
        fill_cnt  = 0;
        max_delay = 0;
        resetn    = 1'b0;
        valid     = 1'b0;
        flush     = 1'b0;
        addr      = '0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_addr", {8'h0, mem_addr}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        resetn = 1'b1;
        tick();

        // Cold miss, then a hit in the same line.
        cpu_read("cold_104", 24'h000104, 32'hA500_0104, 6);
        check_fills("cold_104", 24'h000100);
`ifdef SPIMEM_CACHE_STATS_EN
        check("miss_cnt_1", miss_cnt, 32'd1);
`endif
        cpu_read("hit_10c", 24'h00010C, 32'hA500_010C, 1);
        check("hit_10c_no_fill", fill_log.size(), 0);
`ifdef SPIMEM_CACHE_STATS_EN
        check("hit_cnt_1", hit_cnt, 32'd1);
`endif

        // Conflicting tags on index 0.
        cpu_read("conf_180", 24'h000180, 32'hA500_0180, 6);
        check_fills("conf_180", 24'h000180);
        cpu_read("conf_100", 24'h000100, 32'hA500_0100, 6);
        check_fills("conf_100", 24'h000100);
        check("three_miss_fills", fill_cnt, 12);

        // Populate index 3 so the flush has another line to clear.
        cpu_read("line3_miss", 24'h000130, 32'hA500_0130, 6);
        fill_log.delete();
        cpu_read("line3_hit", 24'h000134, 32'hA500_0134, 1);

        // Flush raised while the 2nd fill word is presented.
        start = fill_cnt;
        valid = 1'b1;
        addr  = 24'h000200;
        lat   = 0;
        while (fill_cnt < start + 2 && lat < 100) begin
            tick();
            lat++;
        end
        check("flush_fill_reached", fill_cnt, start + 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ready(lat);
        valid = 1'b0;
        check("flush_fill_ready", {31'd0, ready}, 32'd1);
        check("flush_fill_rdata", rdata, 32'hA500_0200);
        tick();
        fill_log.delete();
        cpu_read("flush_other_miss", 24'h000130, 32'hA500_0130, 6);
        cpu_read("flush_refill_miss", 24'h000200, 32'hA500_0200, 6);
        fill_log.delete();

        // Flush in IDLE blocks a same-cycle request, which then misses.
        valid = 1'b1;
        addr  = 24'h000130;
        flush = 1'b1;
        tick();
        check("idle_flush_no_ready", {31'd0, ready}, 32'd0);
        check("idle_flush_no_mem", {31'd0, mem_valid}, 32'd0);
        flush = 1'b0;
        wait_ready(lat);
        valid = 1'b0;
        check("idle_flush_rdata", rdata, 32'hA500_0130);
        check("idle_flush_latency", lat, 6);
        tick();
        check_fills("idle_flush", 24'h000130);

        // Reset during the 3rd fill beat.
        start = fill_cnt;
        valid = 1'b1;
        addr  = 24'h000340;
        lat   = 0;
        while (fill_cnt < start + 3 && lat < 100) begin
            tick();
            lat++;
        end
        check("rst_fill_reached", fill_cnt, start + 3);
        resetn = 1'b0;
        valid  = 1'b0;
        tick();
        check("rst_fill_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_fill_ready", {31'd0, ready}, 32'd0);
        check("rst_fill_rdata", rdata, 32'd0);
        resetn = 1'b1;
        tick();
        fill_log.delete();
        cpu_read("rst_reread", 24'h000340, 32'hA500_0340, 6);
        check_fills("rst_reread", 24'h000340);
        cpu_read("rst_other_miss", 24'h000200, 32'hA500_0200, 6);
        fill_log.delete();

        // Random downstream latency on the highest index.
        max_delay = 70;
        tick();
        cpu_read("slow_5f8", 24'h0005F8, 32'hA500_05F8, 0);
        check_fills("slow_5f8", 24'h0005F0);
        cpu_read("slow_5f8_hit", 24'h0005F4, 32'hA500_05F4, 1);
        max_delay = 0;
        tick();
        tick();

        // Top of the address space.
        cpu_read("top_ffc", 24'hFFFFFC, 32'hA5FF_FFFC, 6);
        check_fills("top_ffc", 24'hFFFFF0);
        cpu_read("top_ff0_hit", 24'hFFFFF0, 32'hA5FF_FFF0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
